// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared state encoding and parameter defaults for the sensor frame collector
package sensor_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_DW          = 8;
    localparam int DEF_MAX_VAL     = 100;
    localparam int DEF_TIMEOUT     = 64;
    localparam int DEF_ZERO_REJECT = 1;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - partial-frame age counter; expire flags the last allowed cycle
module frame_timer #(
    parameter int TIMEOUT = sensor_pkg::DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expire = run && (r_cnt == LAST);

endmodule

// File: rtl/sensor_frame_collector.sv
// rtl/sensor_frame_collector.sv - gathers one clamped sample per channel into a frame with
// overwrite, zero-reject, backpressure and timeout discard accounting
module sensor_frame_collector
    import sensor_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DW          = DEF_DW,
    parameter int MAX_VAL     = DEF_MAX_VAL,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int ZERO_REJECT = DEF_ZERO_REJECT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [$clog2(NUM_CH)-1:0] s_ch,
    input  logic [DW-1:0]             s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [NUM_CH*DW-1:0]      m_data,
    output logic                      drop,
    output logic [7:0]                err_cnt
);

    localparam int             CHW  = $clog2(NUM_CH);
    localparam logic [DW-1:0]  MAXV = DW'(MAX_VAL);
    localparam logic [CHW:0]   NCH  = (CHW + 1)'(NUM_CH);

    state_t                 r_state;
    logic [NUM_CH-1:0]      r_fresh;
    logic [DW-1:0]          r_ch [NUM_CH];
    logic                   r_m_valid;
    logic [NUM_CH*DW-1:0]   r_m_data;
    logic                   r_drop;
    logic [7:0]             r_err;

    logic                   w_acc, w_bad, w_overwrite, w_complete, w_has_zero;
    logic                   w_load, w_discard_frame, w_timeout, w_start, w_expire, w_err_evt;
    logic [DW-1:0]          w_sample;
    logic [NUM_CH-1:0]      w_sel, w_fresh_nx;
    logic [DW-1:0]          w_ch_nx [NUM_CH];
    logic [NUM_CH*DW-1:0]   w_frame;

    assign w_acc       = s_valid && ({1'b0, s_ch} < NCH);
    assign w_bad       = s_valid && !w_acc;
    assign w_sample    = (s_data > MAXV) ? MAXV : s_data;
    assign w_sel       = w_acc ? (NUM_CH'(1) << s_ch) : '0;
    assign w_overwrite = |(r_fresh & w_sel);
    assign w_fresh_nx  = r_fresh | w_sel;
    assign w_complete  = w_acc && (&w_fresh_nx);

    // The frame is judged including the sample landing this cycle.
    always_comb begin
        w_has_zero = 1'b0;
        w_frame    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_nx[i]             = w_sel[i] ? w_sample : r_ch[i];
            w_frame[i*DW +: DW]    = w_ch_nx[i];
            w_has_zero             = w_has_zero | (w_ch_nx[i] == '0);
        end
    end

    assign w_load          = w_complete && !((ZERO_REJECT != 0) && w_has_zero)
                             && !(r_m_valid && !m_ready);
    assign w_discard_frame = w_complete && !w_load;
    assign w_timeout       = w_expire && !w_complete;
    assign w_start         = w_acc && !w_complete && ((r_state == ST_IDLE) || w_timeout);
    assign w_err_evt       = w_bad | w_overwrite | w_discard_frame | w_timeout;

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .run    (r_state == ST_COLLECT),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_fresh   <= '0;
            for (int i = 0; i < NUM_CH; i++) r_ch[i] <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_drop    <= 1'b0;
            r_err     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) r_ch[i] <= w_ch_nx[i];

            if (w_complete) begin
                r_fresh <= '0;
                r_state <= ST_IDLE;
            end else if (w_timeout) begin
                // A sample in the expiring cycle seeds the next frame.
                r_fresh <= w_sel;
                r_state <= w_acc ? ST_COLLECT : ST_IDLE;
            end else begin
                r_fresh <= w_fresh_nx;
                if (w_acc) r_state <= ST_COLLECT;
            end

            r_m_valid <= w_load | (r_m_valid & !m_ready);
            if (w_load) r_m_data <= w_frame;

            r_drop <= w_discard_frame | w_timeout;
            if (w_err_evt && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign drop    = r_drop;
    assign err_cnt = r_err;

endmodule

// File: tb/tb_sensor_frame_collector.sv
// tb/tb_sensor_frame_collector.sv - directed self-checking bench for sensor_frame_collector
module tb_sensor_frame_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [0:0]  s_ch = '0;
    logic [7:0]  s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        drop;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sensor_frame_collector #(
        .NUM_CH      (2),
        .DW          (8),
        .MAX_VAL     (100),
        .TIMEOUT     (8),
        .ZERO_REJECT (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ch    (s_ch),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .drop    (drop),
        .err_cnt (err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ch, input logic [7:0] d);
        s_valid = 1'b1;
        s_ch    = ch;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #1;
        check("rst_async_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_async_m_data", {16'd0, m_data}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check("reset_drop", {31'd0, drop}, 32'd0);
        check("reset_err", {24'd0, err_cnt}, 32'd0);

        send(1'b0, 8'd40);
        check("f1_half_valid", {31'd0, m_valid}, 32'd0);
        send(1'b1, 8'd70);
        check("f1_valid", {31'd0, m_valid}, 32'd1);
        check("f1_data", {16'd0, m_data}, 32'h4628);
        check("f1_err", {24'd0, err_cnt}, 32'd0);

        send(1'b0, 8'd10);
        send(1'b1, 8'd20);
        check("bp_drop", {31'd0, drop}, 32'd1);
        check("bp_err", {24'd0, err_cnt}, 32'd1);
        check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
        check("bp_hold_data", {16'd0, m_data}, 32'h4628);
        tick();
        check("bp_drop_pulse", {31'd0, drop}, 32'd0);
        m_ready = 1'b1;
        tick();
        check("bp_release", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b0;

        send(1'b0, 8'd150);
        send(1'b1, 8'd0);
        check("zero_drop", {31'd0, drop}, 32'd1);
        check("zero_err", {24'd0, err_cnt}, 32'd2);
        check("zero_valid", {31'd0, m_valid}, 32'd0);

        send(1'b0, 8'd200);
        send(1'b1, 8'd60);
        check("clamp_valid", {31'd0, m_valid}, 32'd1);
        check("clamp_data", {16'd0, m_data}, 32'h3C64);

        send(1'b0, 8'd5);
        check("b2b_hold", {16'd0, m_data}, 32'h3C64);
        m_ready = 1'b1;
        send(1'b1, 8'd6);
        check("b2b_valid", {31'd0, m_valid}, 32'd1);
        check("b2b_data", {16'd0, m_data}, 32'h0605);
        tick();
        check("b2b_fall", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b0;
        check("b2b_err", {24'd0, err_cnt}, 32'd2);

        send(1'b0, 8'd11);
        repeat (7) tick();
        check("to1_early", {31'd0, drop}, 32'd0);
        send(1'b0, 8'd22);
        check("to1_drop", {31'd0, drop}, 32'd1);
        check("to1_err", {24'd0, err_cnt}, 32'd3);
        send(1'b1, 8'd33);
        check("to1_restart_valid", {31'd0, m_valid}, 32'd1);
        check("to1_restart_data", {16'd0, m_data}, 32'h2116);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        send(1'b0, 8'd44);
        repeat (7) tick();
        check("to2_early", {31'd0, drop}, 32'd0);
        tick();
        check("to2_drop", {31'd0, drop}, 32'd1);
        check("to2_err", {24'd0, err_cnt}, 32'd4);
        tick();
        check("to2_pulse", {31'd0, drop}, 32'd0);

        for (int i = 0; i < 300; i++) send(1'b0, 8'd1);
        check("sat_err", {24'd0, err_cnt}, 32'd255);
        send(1'b1, 8'd8);
        check("sat_frame_data", {16'd0, m_data}, 32'h0801);
        check("sat_hold", {24'd0, err_cnt}, 32'd255);

        send(1'b0, 8'd9);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_data", {16'd0, m_data}, 32'd0);
        check("mid_rst_err", {24'd0, err_cnt}, 32'd0);
        check("mid_rst_drop", {31'd0, drop}, 32'd0);
        tick();
        rst = 1'b0;
        check("post_rst_drop", {31'd0, drop}, 32'd0);
        send(1'b1, 8'd5);
        check("post_rst_partial", {31'd0, m_valid}, 32'd0);
        send(1'b0, 8'd6);
        check("post_rst_valid", {31'd0, m_valid}, 32'd1);
        check("post_rst_data", {16'd0, m_data}, 32'h0506);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_frame_collector.md
SENSOR_FRAME_COLLECTOR -- requirements
Module: sensor_frame_collector

Interface
REQ-001 Parameter NUM_CH, default 2, number of sensor channels per frame (legal 2..8).
REQ-002 Parameter DW, default 8, sample width in bits.
REQ-003 Parameter MAX_VAL, default 100, clamp ceiling applied to every sample.
REQ-004 Parameter TIMEOUT, default 64, cycles a partial frame may wait before it is discarded (legal 2..65535).
REQ-005 Parameter ZERO_REJECT, default 1, 1 = a frame containing any zero sample is discarded, 0 = zero samples are accepted.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 s_valid  in  1  sample strobe; a sample is taken on every cycle it is high.
REQ-009 s_ch  in  clog2(NUM_CH)  channel index of the sample.
REQ-010 s_data  in  DW  sample value.
REQ-011 m_valid  out  1  completed frame available.
REQ-012 m_ready  in  1  downstream accepts the frame.
REQ-013 m_data  out  NUM_CH*DW  frame, channel 0 in the least significant DW bits.
REQ-014 drop  out  1  one-cycle pulse on any frame discard.
REQ-015 err_cnt  out  8  saturating count of discards and overwrites.

Function
REQ-016 The block SHALL use state machine IDLE (no fresh channel), COLLECT (at least one fresh channel, frame incomplete).
REQ-017 A sample with s_data > MAX_VAL SHALL be stored as MAX_VAL.
REQ-018 A sample with s_ch >= NUM_CH SHALL be ignored and SHALL increment err_cnt.
REQ-019 An accepted sample SHALL write its channel register and set that channel's fresh bit; IDLE -> COLLECT.
REQ-020 A sample on an already fresh channel SHALL overwrite the value and SHALL increment err_cnt.
REQ-021 When all fresh bits are set, including via the sample in the current cycle, the frame SHALL complete: fresh bits clear and the state returns to IDLE.
REQ-022 On completion, if ZERO_REJECT = 1 and any channel is zero, the frame SHALL be discarded: drop pulse, err_cnt +1, m_valid unaffected.
REQ-023 Otherwise the frame SHALL load the output buffer; m_valid rises the cycle after the completing sample (latency 1).
REQ-024 m_data SHALL hold stable while m_valid = 1 and m_ready = 0.
REQ-025 m_valid SHALL fall the cycle after m_valid = 1 and m_ready = 1, unless a new frame loads in that same cycle, in which case m_valid stays high with the new data.
REQ-026 A frame completing while m_valid = 1 and m_ready = 0 SHALL be discarded (drop, err_cnt +1); the buffered frame is retained.
REQ-027 The timeout counter SHALL clear on entry to COLLECT and increment each cycle in COLLECT; at TIMEOUT-1 with no completion, the partial frame SHALL be discarded (drop, err_cnt +1, fresh bits clear).
REQ-028 A sample arriving in the timeout cycle SHALL start a new frame: only its fresh bit set, state COLLECT, counter 0.
REQ-029 Completion SHALL take priority over timeout in the same cycle.
REQ-030 err_cnt SHALL saturate at 255 and increment by at most 1 per cycle.
REQ-031 drop SHALL be a single-cycle pulse per discard event.

Reset
REQ-032 rst high SHALL immediately force IDLE, clear fresh bits, channel registers, the timeout counter, m_valid, m_data, drop and err_cnt to 0.
REQ-033 Reset mid-frame or with m_valid high SHALL lose the frame without a drop pulse.
REQ-034 The first sample SHALL be accepted on the first rising edge after rst falls.

Structure
REQ-035 Shared package sensor_pkg SHALL hold the state enum and the parameter defaults (NUM_CH, DW, MAX_VAL, TIMEOUT).
REQ-036 The timeout counter SHALL be a sub-module frame_timer (inputs start, run; output expire), parametrised by TIMEOUT.
REQ-037 The parallel m_data output SHALL feed the existing fuzzy risk engine, with m_valid taking the role of its evaluate enable.

Verification
REQ-038 NUM_CH = 2: ch0 = 40, then ch1 = 70 -> one cycle later m_valid = 1, m_data = {70,40}.
REQ-039 ch0 = 150, ch1 = 0, ZERO_REJECT = 1 -> drop pulse, err_cnt = 1, m_valid stays 0; ch0 is stored clamped to 100.
REQ-040 ch0 only, TIMEOUT = 8 -> drop pulse in the 8th COLLECT cycle; a sample in that cycle starts a new frame.
REQ-041 m_ready = 0, two complete frames -> second frame dropped, m_data still holds the first; m_ready = 1 -> m_valid falls next cycle.
REQ-042 300 overwrite events -> err_cnt = 255; rst asserted mid-frame -> all outputs 0 asynchronously, no drop pulse.
